pkt_fifo: RTL and testbench
===========================

// Module: pkt_fifo
// PURPOSE
//  Packet FIFO between pkt_spi_write (writer) and the packet consumer (reader); 8-bit data + last flag per entry.
//  Bytes are visible to the reader only once their packet's last byte is written (commit), so a partial packet is never read.
//  Overflow drops the whole in-flight packet. The writer may ignore wr_full: a packet that does not fit is discarded.
// PARAMETERS
//  AW        8   log2 depth in entries; DEPTH = 2**AW, all DEPTH entries usable
// PORTS
//  clk          in   1     system clock
//  rst          in   1     reset, asynchronous, active-high
//  wr_data      in   8     write byte
//  wr_last      in   1     byte is last of packet
//  wr_ena       in   1     write strobe, one byte per cycle
//  wr_full      out  1     physical storage full (incl. uncommitted bytes)
//  rd_data      out  8     read byte, valid cycle after rd_ena
//  rd_last      out  1     last flag of rd_data
//  rd_ena       in   1     read strobe
//  rd_empty     out  1     no committed byte available
//  ovf          out  1     sticky: a packet was dropped
//  ovf_clr      in   1     clears ovf
//  lvl          out  AW+1  committed bytes held (see CONFIGURATION)
//  pkt_cnt      out  AW+1  committed packets not yet fully read (see CONFIGURATION)
// BEHAVIOUR
//  - Pointers wp (write), cp (commit), rp (read), each AW+1 bits, wrap modulo 2**(AW+1); MSB distinguishes full/empty.
//  - wr_full = (wp - rp) == DEPTH; rd_empty = (rp == cp). Both combinational from registered pointers.
//  - Write FSM, two states:
//    ACCEPT: wr_ena & ~wr_full -> mem[wp] <= {wr_last,wr_data}, wp++; if wr_last, cp <= wp+1 (commit).
//            wr_ena & wr_full  -> wp <= cp, ovf <= 1; if ~wr_last go DISCARD, else stay (packet ended, dropped).
//    DISCARD: wr_ena ignored, nothing stored; wr_ena & wr_last -> ACCEPT.
//  - Full evaluated on pre-cycle state: write at full with simultaneous read still drops.
//  - Packets longer than DEPTH are always dropped; no deadlock, FIFO recovers at next packet.
//  - Read: rd_ena & ~rd_empty -> rp++, {rd_last,rd_data} <= mem[rp] on next edge (1-cycle latency, EBR-style);
//    rd_ena while empty ignored, rd_data/rd_last hold previous value.
//  - Commit and read in same cycle: both apply; rd_empty reflects new cp next cycle.
//  - ovf_clr and a new drop in same cycle: ovf stays 1 (set wins).
//  - Reset (any time, incl. mid-packet): wp=cp=rp=0, state ACCEPT, ovf=0, rd_data=0, rd_last=0,
//    rd_empty=1, wr_full=0, lvl=0, pkt_cnt=0. In-flight and stored packets lost.
// CONFIGURATION
//  PKT_FIFO_STATS_EN defined: lvl = cp - rp; pkt_cnt register, +1 on commit, -1 on read of a last-flagged entry,
//    both same cycle -> unchanged.
//  Not defined: lvl and pkt_cnt tied to 0, no counter logic; all other behaviour identical.
// TESTING
//  - Write 3-byte pkt 11,22,33(last) -> rd_empty stays 1 until cycle after 33; reads give 11,22,33 with rd_last only on 33.
//  - Write 2 bytes no last -> rd_empty stays 1, lvl=0; send last byte -> 3 bytes readable, pkt_cnt=1 (STATS_EN).
//  - AW=2: fill 4 bytes across 2 committed pkts, write 5th -> ovf=1, wp rewinds to cp, bytes until last dropped, prior pkts intact.
//  - AW=2: 6-byte packet into empty FIFO -> dropped entirely, ovf=1; next 2-byte pkt accepted and read correctly.
//  - Continuous write/read 1000 random pkts with pointer wrap -> byte stream and last flags match model, ovf=0.
//  - Assert rst mid-packet and mid-read -> all outputs at reset values next cycle; new packet after release reads correctly.

Source files
------------

// File: rtl/pkt_fifo.sv
// Packet FIFO: bytes become readable only after their packet's last byte is committed; overflow drops the packet.
// Optional occupancy/packet statistics (lvl, pkt_cnt) are enabled with `define PKT_FIFO_STATS_EN.
module pkt_fifo #(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  input  logic        wr_ena,
  output logic        wr_full,
  output logic [7:0]  rd_data,
  output logic        rd_last,
  input  logic        rd_ena,
  output logic        rd_empty,
  output logic        ovf,
  input  logic        ovf_clr,
  output logic [AW:0] lvl,
  output logic [AW:0] pkt_cnt
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_V   = {{AW{1'b0}}, 1'b1};

  typedef enum logic {ACCEPT, DISCARD} state_t;

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wp_reg, cp_reg, rp_reg;
  logic [AW:0] used;
  logic [7:0]  rd_data_reg;
  logic        rd_last_reg;
  logic        ovf_reg;
  state_t      state_reg;
  logic        wr_acc, rd_fire;

  assign used     = wp_reg - rp_reg;
  assign wr_full  = (used == DEPTH_V);
  assign rd_empty = (rp_reg == cp_reg);
  assign wr_acc   = (state_reg == ACCEPT) && wr_ena && !wr_full;
  assign rd_fire  = rd_ena && !rd_empty;

  assign rd_data = rd_data_reg;
  assign rd_last = rd_last_reg;
  assign ovf     = ovf_reg;

  // Storage has no reset so it maps onto block RAM; the slot being written is never the slot being read.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wp_reg[AW-1:0]] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_reg      <= '0;
      cp_reg      <= '0;
      rp_reg      <= '0;
      rd_data_reg <= '0;
      rd_last_reg <= 1'b0;
      ovf_reg     <= 1'b0;
      state_reg   <= ACCEPT;
    end else begin
      if (rd_fire) begin
        rp_reg                     <= rp_reg + ONE_V;
        {rd_last_reg, rd_data_reg} <= mem[rp_reg[AW-1:0]];
      end
      if (ovf_clr)
        ovf_reg <= 1'b0;
      case (state_reg)
        ACCEPT: begin
          if (wr_ena) begin
            if (!wr_full) begin
              wp_reg <= wp_reg + ONE_V;
              if (wr_last)
                cp_reg <= wp_reg + ONE_V;
            end else begin
              // Rewind over the uncommitted bytes; a later set overrides ovf_clr above.
              wp_reg  <= cp_reg;
              ovf_reg <= 1'b1;
              if (!wr_last)
                state_reg <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (wr_ena && wr_last)
            state_reg <= ACCEPT;
        end
        default: state_reg <= ACCEPT;
      endcase
    end
  end

`ifdef PKT_FIFO_STATS_EN
  logic [AW:0] pkt_cnt_reg;
  logic        pkt_inc, pkt_dec;

  assign pkt_inc = wr_acc && wr_last;
  assign pkt_dec = rd_fire && mem[rp_reg[AW-1:0]][8];
  assign lvl     = cp_reg - rp_reg;
  assign pkt_cnt = pkt_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_reg <= '0;
    end else begin
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_cnt_reg <= pkt_cnt_reg + ONE_V;
        2'b01:   pkt_cnt_reg <= pkt_cnt_reg - ONE_V;
        default: pkt_cnt_reg <= pkt_cnt_reg;
      endcase
    end
  end
`else
  assign lvl     = '0;
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_fifo.sv
// Scoreboard bench for pkt_fifo (AW=2): directed commit/overflow/reset cases plus a random packet stream.
module tb_pkt_fifo;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    wr_data = '0;
  logic          wr_last = 1'b0;
  logic          wr_ena = 1'b0;
  logic          wr_full;
  logic [7:0]    rd_data;
  logic          rd_last;
  logic          rd_ena = 1'b0;
  logic          rd_empty;
  logic          ovf;
  logic          ovf_clr = 1'b0;
  logic [AW:0]   lvl;
  logic [AW:0]   pkt_cnt;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  pkt_fifo #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_data(wr_data), .wr_last(wr_last), .wr_ena(wr_ena), .wr_full(wr_full),
    .rd_data(rd_data), .rd_last(rd_last), .rd_ena(rd_ena), .rd_empty(rd_empty),
    .ovf(ovf), .ovf_clr(ovf_clr), .lvl(lvl), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_stat(string name, int act, int exp);
`ifdef PKT_FIFO_STATS_EN
    chk(name, act, exp);
`else
    chk(name, act, 0);
`endif
  endtask

  // Monitor: a read accepted at this edge presents its byte just after the edge.
  always @(posedge clk) begin
    logic fire;
    logic [8:0] e;
    fire = rd_ena && !rd_empty && !rst;
    if (fire) begin
      #1;
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("rd data=%02h last=%0d exp=%02h/%0d", rd_data, rd_last, e[7:0], e[8]);
        chk("rd_data", int'(rd_data), int'(e[7:0]));
        chk("rd_last", int'(rd_last), int'(e[8]));
      end
    end
  end

  task automatic drive(bit we, logic [7:0] d, bit l, bit re, bit clr = 1'b0);
    @(negedge clk);
    wr_ena = we; wr_data = d; wr_last = l; rd_ena = re; ovf_clr = clr;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wr(logic [7:0] d, bit l);
    drive(1'b1, d, l, 1'b0);
  endtask

  task automatic rd_n(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic push(logic [7:0] d, bit l);
    exp_q.push_back({l, d});
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_rd_empty"}, int'(rd_empty), 1);
    chk({tag, "_wr_full"},  int'(wr_full), 0);
    chk({tag, "_ovf"},      int'(ovf), 0);
    chk({tag, "_rd_data"},  int'(rd_data), 0);
    chk({tag, "_rd_last"},  int'(rd_last), 0);
    chk({tag, "_lvl"},      int'(lvl), 0);
    chk({tag, "_pkt_cnt"},  int'(pkt_cnt), 0);
  endtask

  initial begin
    int started, occ, idx, len, cyc, k;
    bit inpkt, we, re, l;
    logic [7:0] d;
    logic [8:0] pbuf[DEPTH];

    repeat (2) @(negedge clk);
    chk_reset_state("rst0");
    rst = 1'b0;
    idle();

    // 3-byte packet: invisible until the last byte commits
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    chk("t1_empty_after_11", int'(rd_empty), 1);
    wr(8'h33, 1'b1);
    chk("t1_empty_after_22", int'(rd_empty), 1);
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b1);
    idle();
    chk("t1_empty_after_33", int'(rd_empty), 0);
    chk_stat("t1_lvl", int'(lvl), 3);
    chk_stat("t1_pkt_cnt", int'(pkt_cnt), 1);
    rd_n(3);
    idle();
    chk("t1_drained", int'(rd_empty), 1);
    chk_stat("t1_pkt_cnt_0", int'(pkt_cnt), 0);

    // partial packet then completion
    wr(8'h44, 1'b0);
    wr(8'h55, 1'b0);
    idle();
    chk("t2_partial_empty", int'(rd_empty), 1);
    chk_stat("t2_partial_lvl", int'(lvl), 0);
    wr(8'h66, 1'b1);
    push(8'h44, 1'b0); push(8'h55, 1'b0); push(8'h66, 1'b1);
    idle();
    chk("t2_commit_empty", int'(rd_empty), 0);
    chk_stat("t2_lvl", int'(lvl), 3);
    chk_stat("t2_pkt_cnt", int'(pkt_cnt), 1);
    rd_n(3);
    idle();
    chk("t2_drained", int'(rd_empty), 1);

    // fill with two packets, overflow drops the third
    wr(8'h01, 1'b0); wr(8'h02, 1'b1); push(8'h01, 1'b0); push(8'h02, 1'b1);
    wr(8'h03, 1'b0); wr(8'h04, 1'b1); push(8'h03, 1'b0); push(8'h04, 1'b1);
    idle();
    chk("t3_full", int'(wr_full), 1);
    chk_stat("t3_lvl", int'(lvl), 4);
    chk_stat("t3_pkt_cnt", int'(pkt_cnt), 2);
    wr(8'h05, 1'b0);
    wr(8'h06, 1'b0);
    wr(8'h07, 1'b1);
    idle();
    chk("t3_ovf", int'(ovf), 1);
    chk("t3_still_full", int'(wr_full), 1);
    rd_n(4);
    idle();
    chk("t3_drained", int'(rd_empty), 1);
    chk("t3_not_full", int'(wr_full), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle();
    chk("t3_ovf_clr", int'(ovf), 0);

    // write at full with simultaneous read and ovf_clr: still dropped, set wins
    wr(8'h08, 1'b0); wr(8'h09, 1'b0); wr(8'h0A, 1'b0); wr(8'h0B, 1'b1);
    push(8'h08, 1'b0); push(8'h09, 1'b0); push(8'h0A, 1'b0); push(8'h0B, 1'b1);
    drive(1'b1, 8'h0C, 1'b1, 1'b1, 1'b1);
    idle();
    chk("t3b_ovf_set_wins", int'(ovf), 1);
    chk_stat("t3b_lvl", int'(lvl), 3);
    chk_stat("t3b_pkt_cnt", int'(pkt_cnt), 1);
    wr(8'h0D, 1'b1); push(8'h0D, 1'b1);
    idle();
    chk_stat("t3b_lvl2", int'(lvl), 4);
    chk_stat("t3b_pkt_cnt2", int'(pkt_cnt), 2);
    rd_n(4);
    idle();
    chk("t3b_drained", int'(rd_empty), 1);
    chk_stat("t3b_pkt_cnt0", int'(pkt_cnt), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle();

    // packet longer than DEPTH is dropped, next packet fine
    for (int i = 1; i <= 6; i++) wr(8'hE0 + 8'(i), (i == 6));
    idle();
    chk("t4_ovf", int'(ovf), 1);
    chk("t4_empty", int'(rd_empty), 1);
    chk("t4_not_full", int'(wr_full), 0);
    chk_stat("t4_lvl", int'(lvl), 0);
    wr(8'hA1, 1'b0); wr(8'hA2, 1'b1); push(8'hA1, 1'b0); push(8'hA2, 1'b1);
    idle();
    chk_stat("t4_lvl2", int'(lvl), 2);
    rd_n(2);
    idle();
    chk("t4_drained", int'(rd_empty), 1);

    // reset mid-packet and mid-read (ovf still set from above)
    wr(8'h5A, 1'b0); wr(8'h5B, 1'b1); push(8'h5A, 1'b0); push(8'h5B, 1'b1);
    rd_n(1);
    @(negedge clk);
    exp_q.delete();
    rst = 1'b1; wr_ena = 1'b1; wr_data = 8'h77; wr_last = 1'b0; rd_ena = 1'b1;
    @(negedge clk);
    chk_reset_state("rst1");
    wr_ena = 1'b0; rd_ena = 1'b0; rst = 1'b0;
    wr(8'hC1, 1'b0); wr(8'hC2, 1'b1); push(8'hC1, 1'b0); push(8'hC2, 1'b1);
    idle();
    chk_stat("t6_lvl", int'(lvl), 2);
    rd_n(2);
    idle();
    chk("t6_drained", int'(rd_empty), 1);

    // random packet stream with pointer wrap; writer only starts packets that fit
    started = 0; occ = 0; idx = 0; len = 0; cyc = 0; inpkt = 1'b0;
    while ((started < 1000 || inpkt) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      we = 1'b0; re = 1'b0; l = 1'b0; d = 8'h00;
      if (!rd_empty && $urandom_range(0, 3) != 0) re = 1'b1;
      if (!inpkt && started < 1000) begin
        if (len == 0) len = $urandom_range(1, DEPTH);
        if (DEPTH - occ >= len) begin
          inpkt = 1'b1; idx = 0; started++;
        end
      end
      if (inpkt && $urandom_range(0, 4) != 0) begin
        we = 1'b1;
        d = 8'($urandom);
        l = (idx == len - 1);
        pbuf[idx] = {l, d};
        idx++;
        occ++;
        if (l) begin
          for (int i = 0; i < len; i++) exp_q.push_back(pbuf[i]);
          inpkt = 1'b0;
          len = 0;
        end
      end
      if (re) occ--;
      wr_ena = we; wr_data = d; wr_last = l; rd_ena = re; ovf_clr = 1'b0;
    end
    chk("rand_timeout", int'(cyc >= 40000), 0);
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      wr_ena = 1'b0;
      rd_ena = !rd_empty;
      k++;
    end
    idle();
    chk("rand_queue_left", exp_q.size(), 0);
    chk("rand_ovf", int'(ovf), 0);
    chk("rand_empty", int'(rd_empty), 1);
    chk_stat("rand_lvl", int'(lvl), 0);
    chk_stat("rand_pkt_cnt", int'(pkt_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
